// File: rtl/ecc_enc_scheduler.sv
// Round-robin scheduler sharing one external SECDED 2D-parity encoder among NUM_REQ requesters.
// Optional ack/nack resend path: define ECC_ENC_SCHED_RETRY_EN (default build has no WAIT/retry/drop).
module ecc_enc_scheduler #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned COL_NUM   = 4,
    parameter int unsigned ROW_NUM   = 4,
    parameter int unsigned MAX_RETRY = 3,
    localparam int unsigned DW  = COL_NUM * ROW_NUM,
    localparam int unsigned CW  = (COL_NUM + 1) * (ROW_NUM + 1),
    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [DW-1:0]         enc_data_in,
    input  logic [CW-1:0]         enc_data_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CW-1:0]         out_data,
    output logic [IDW-1:0]        out_id,
    input  logic                  resp_valid,
    input  logic                  resp_nack,
    output logic                  busy,
    output logic                  drop
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        SEND = 2'd2,
        WAIT = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_inc;
    logic [IDW-1:0] hold_id;
    logic [IDW-1:0] win_id;
    logic [DW-1:0]  hold_data;
    logic [DW-1:0]  win_data;
    logic           win_found;
    logic           accept;
    logic           release_word;
    int unsigned    idx;

`ifdef ECC_ENC_SCHED_RETRY_EN
    localparam int unsigned RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RCW-1:0] retry_cnt;
    logic           resend;
    logic           drop_nxt;
`else
    logic unused_resp;
    assign unused_resp = resp_valid ^ resp_nack;
    assign drop        = 1'b0;
`endif

    // Round-robin search starting at ptr; first valid requester wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr) + k) % NUM_REQ;
            if (!win_found && req_valid[IDW'(idx)]) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
            end
        end
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_id == IDW'(i)) begin
                win_data = req_data[i*DW +: DW];
            end
        end
    end

    assign ptr_inc     = (32'(hold_id) == NUM_REQ - 1) ? '0 : hold_id + IDW'(1);
    assign req_ready   = (accept && !reset) ? (NUM_REQ'(1) << win_id) : '0;
    assign enc_data_in = hold_data;
    assign out_valid   = (state == SEND);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and transition strobes.
    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        release_word = 1'b0;
`ifdef ECC_ENC_SCHED_RETRY_EN
        resend       = 1'b0;
        drop_nxt     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (win_found) begin
                    accept    = 1'b1;
                    state_nxt = ENC;
                end
            end
            ENC: state_nxt = SEND;
            SEND: begin
                if (out_ready) begin
`ifdef ECC_ENC_SCHED_RETRY_EN
                    state_nxt = WAIT;
`else
                    state_nxt    = IDLE;
                    release_word = 1'b1;
`endif
                end
            end
            WAIT: begin
`ifdef ECC_ENC_SCHED_RETRY_EN
                if (resp_valid) begin
                    if (!resp_nack) begin
                        state_nxt    = IDLE;
                        release_word = 1'b1;
                    end else if (retry_cnt < RCW'(MAX_RETRY)) begin
                        state_nxt = SEND;
                        resend    = 1'b1;
                    end else begin
                        state_nxt    = IDLE;
                        release_word = 1'b1;
                        drop_nxt     = 1'b1;
                    end
                end
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word capture, codeword register and pointer/retry bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            hold_id   <= '0;
            hold_data <= '0;
            out_data  <= '0;
            out_id    <= '0;
`ifdef ECC_ENC_SCHED_RETRY_EN
            retry_cnt <= '0;
            drop      <= 1'b0;
`endif
        end else begin
            if (accept) begin
                hold_data <= win_data;
                hold_id   <= win_id;
            end
            if (state == ENC) begin
                out_data <= enc_data_out;
                out_id   <= hold_id;
            end
            if (release_word) begin
                ptr <= ptr_inc;
            end
`ifdef ECC_ENC_SCHED_RETRY_EN
            if (accept) begin
                retry_cnt <= '0;
            end else if (resend && retry_cnt != RCW'(MAX_RETRY)) begin
                retry_cnt <= retry_cnt + RCW'(1);
            end
            drop <= drop_nxt;
`endif
        end
    end

endmodule

// File: doc/ecc_enc_scheduler.md
ECC_ENC_SCHEDULER -- requirements
Module: ecc_enc_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one SECDED 2D-parity encoder.
REQ-002 The block SHALL have parameters COL_NUM and ROW_NUM, both default 4, meaning the encoder geometry. Derived widths: DW = COL_NUM*ROW_NUM and CW = (COL_NUM+1)*(ROW_NUM+1).
REQ-003 The block SHALL have parameter MAX_RETRY, default 3, meaning the maximum number of resends after nack.
REQ-004 Port: clk, input, 1, clock.
REQ-005 Port: reset, input, 1, synchronous, active-high.
REQ-006 Port: req_valid, input, NUM_REQ, request per requester.
REQ-007 Port: req_data, input, NUM_REQ*DW, requester i's data in slice [i*DW +: DW].
REQ-008 Port: req_ready, output, NUM_REQ, one-hot accept.
REQ-009 Port: enc_data_in, output, DW, data to the external encoder.
REQ-010 Port: enc_data_out, input, CW, combinational codeword returned by the encoder.
REQ-011 Port: out_valid, output, 1; out_ready, input, 1; out_data, output, CW; out_id, output, clog2(NUM_REQ).
REQ-012 Port: resp_valid, input, 1; resp_nack, input, 1, downstream acknowledgement (nack=1 means resend).
REQ-013 Port: busy, output, 1; drop, output, 1, one-cycle pulse when a word is abandoned.

Function
REQ-014 The FSM SHALL have the states IDLE, ENC, SEND and WAIT, with the following transitions:
- IDLE -> ENC when any req_valid is high.
- ENC -> SEND always.
- SEND -> WAIT on out_valid&&out_ready.
- WAIT -> IDLE on resp_valid with nack=0.
- WAIT -> SEND on resp_valid with nack=1 and retry_cnt<MAX_RETRY.
- WAIT -> IDLE with drop=1 on resp_valid with nack=1 and retry_cnt==MAX_RETRY.
REQ-015 Arbitration SHALL be round-robin: the search starts at pointer ptr, and the winner is the first i (ptr, ptr+1, ... mod NUM_REQ) with req_valid[i]=1.
REQ-016 req_ready[winner] SHALL be high combinationally only in IDLE. At that edge, req_data slice and winner index SHALL be latched into hold_data/hold_id.
REQ-017 In every state, enc_data_in SHALL equal hold_data. In ENC, enc_data_out SHALL be registered into out_data.
REQ-018 out_valid SHALL be high exactly in SEND. The first out_valid SHALL occur 2 cycles after the accepting edge.
REQ-019 out_data and out_id SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 retry_cnt SHALL be cleared on accept and incremented on each nack-triggered resend. It SHALL saturate and never wrap.
REQ-021 On leaving WAIT to IDLE (ack or drop), ptr SHALL become (hold_id+1) mod NUM_REQ. ptr SHALL be unchanged otherwise.
REQ-022 resp_valid SHALL be ignored outside WAIT.
REQ-023 req_valid changes outside IDLE SHALL have no effect.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 Simultaneous resp_valid and new req_valid in WAIT SHALL be handled as follows: the return to IDLE has priority, and the arbitration occurs in the next cycle.

Reset
REQ-026 reset SHALL be synchronous, active-high, on clk. It SHALL force state=IDLE, ptr=0, retry_cnt=0, out_data=0, out_id=0, hold_data=0, out_valid=0, drop=0 and req_ready=0.
REQ-027 Reset asserted in any state (including mid-SEND) SHALL abandon the word without a drop pulse.

Configuration
REQ-028 Macro ECC_ENC_SCHED_RETRY_EN SHALL control the retry feature:
- Defined: WAIT state, retry_cnt and drop SHALL be implemented as specified above.
- Undefined: SEND SHALL go directly to IDLE on handshake (ptr update as in REQ-021), resp_valid and resp_nack SHALL be ignored, and drop SHALL be tied to 0.

Verification
REQ-029 Single request: reset, then req_valid=4'b0001 with data 16'h0001 and the reference encoder attached -> req_ready=4'b0001 at t, out_valid at t+2 with out_data=25'h1100011 and out_id=0.
REQ-030 Fairness: req_valid=4'b1111 held, out_ready=1, resp ack each word -> grant order 0,1,2,3,0.
REQ-031 Backpressure: out_ready=0 for 5 cycles in SEND -> out_valid held, out_data unchanged, no new req_ready.
REQ-032 Retry: three nacks then an ack -> 4 SEND phases with identical out_data, drop=0. Four nacks -> drop pulse of 1 cycle and return to IDLE with ptr advanced.
REQ-033 Reset mid-SEND: reset asserted while out_valid=1 -> next cycle out_valid=0, busy=0, ptr=0.
REQ-034 Macro undefined: resp_nack=1 -> no resend, next grant follows immediately after handshake.
